// File: rtl/rvb_crc_arbiter.sv
// rvb_crc_arbiter: round-robin sharing of one rvb_crc between two requesters; an in-order tag FIFO routes results back.
// Define RVB_CRC_ARB_STATS_EN to add the stat_issue0/stat_issue1/stat_stall counters.
module rvb_crc_arbiter #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req0_din_valid,
   output logic            req0_din_ready,
   input  logic [XLEN-1:0] req0_din_rs1,
   input  logic [2:0]      req0_din_insn,
   output logic            req0_dout_valid,
   input  logic            req0_dout_ready,
   output logic [XLEN-1:0] req0_dout_rd,
   input  logic            req1_din_valid,
   output logic            req1_din_ready,
   input  logic [XLEN-1:0] req1_din_rs1,
   input  logic [2:0]      req1_din_insn,
   output logic            req1_dout_valid,
   input  logic            req1_dout_ready,
   output logic [XLEN-1:0] req1_dout_rd,
   output logic            crc_din_valid,
   input  logic            crc_din_ready,
   output logic [XLEN-1:0] crc_din_rs1,
   output logic            crc_din_insn20,
   output logic            crc_din_insn21,
   output logic            crc_din_insn23,
   input  logic            crc_dout_valid,
   output logic            crc_dout_ready,
   input  logic [XLEN-1:0] crc_dout_rd
`ifdef RVB_CRC_ARB_STATS_EN
   ,
   output logic [31:0]     stat_issue0,
   output logic [31:0]     stat_issue1,
   output logic [31:0]     stat_stall
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic             prio_q, prio_d;
   logic [DEPTH-1:0] tags_q, tags_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             can_issue, sel, push, pop, head, nonempty;
   logic [2:0]       insn;

   // Issue depends only on the registered count, so a same-cycle pop never frees a slot for a push.
   always_comb begin
      can_issue       = !reset && (count_q < CW'(DEPTH));
      sel             = (req0_din_valid && req1_din_valid) ? prio_q : req1_din_valid;
      insn            = sel ? req1_din_insn : req0_din_insn;
      crc_din_valid   = can_issue && (req0_din_valid || req1_din_valid);
      crc_din_rs1     = sel ? req1_din_rs1 : req0_din_rs1;
      crc_din_insn23  = insn[2];
      crc_din_insn21  = insn[1];
      crc_din_insn20  = insn[0];
      req0_din_ready  = can_issue && crc_din_ready && !sel && req0_din_valid;
      req1_din_ready  = can_issue && crc_din_ready && sel && req1_din_valid;
      push            = crc_din_valid && crc_din_ready;
      head            = tags_q[rd_ptr_q];
      nonempty        = !reset && (count_q != '0);
      req0_dout_valid = nonempty && crc_dout_valid && !head;
      req1_dout_valid = nonempty && crc_dout_valid && head;
      req0_dout_rd    = crc_dout_rd;
      req1_dout_rd    = crc_dout_rd;
      crc_dout_ready  = nonempty && (head ? req1_dout_ready : req0_dout_ready);
      pop             = crc_dout_valid && crc_dout_ready;
      tags_d          = tags_q;
      if (push) tags_d[wr_ptr_q] = sel;
      wr_ptr_d        = wr_ptr_q + AW'(push);
      rd_ptr_d        = rd_ptr_q + AW'(pop);
      count_d         = count_q + CW'(push) - CW'(pop);
      prio_d          = push ? !sel : prio_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prio_q   <= 1'b0;
         tags_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         prio_q   <= prio_d;
         tags_q   <= tags_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef RVB_CRC_ARB_STATS_EN
   logic [31:0] stat_issue0_q, stat_issue0_d, stat_issue1_q, stat_issue1_d, stat_stall_q, stat_stall_d;

   always_comb begin
      stat_issue0_d = stat_issue0_q + 32'(push && !sel);
      stat_issue1_d = stat_issue1_q + 32'(push && sel);
      stat_stall_d  = stat_stall_q + 32'((req0_din_valid || req1_din_valid) && !push);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_issue0_q <= '0;
         stat_issue1_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         stat_issue0_q <= stat_issue0_d;
         stat_issue1_q <= stat_issue1_d;
         stat_stall_q  <= stat_stall_d;
      end
   end

   assign stat_issue0 = stat_issue0_q;
   assign stat_issue1 = stat_issue1_q;
   assign stat_stall  = stat_stall_q;
`endif
endmodule
